// File: rtl/absval_pkg.sv
// Shared types and helpers for the round-robin absolute-value scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ABS_WIDTH / ABS_N_REQ / ABS_ID_W : datapath geometry for the stage record.
//                                      The top's WIDTH/N_REQ must match these.
//   stage_t                          : pipeline stage record (valid, data, id, ovf).
//   is_min_neg_f(x)                  : x is the most-negative two's complement value.
//   absval_f(x)                      : |x|, truncated to ABS_WIDTH bits.
// Optional feature macro: ABSVAL_SAT_EN. When defined, |most-negative|
// saturates to the largest positive value instead of wrapping to itself.
package absval_pkg;

  localparam int unsigned ABS_WIDTH = 8;
  localparam int unsigned ABS_N_REQ = 4;
  localparam int unsigned ABS_ID_W  = $clog2(ABS_N_REQ);

  typedef logic [ABS_WIDTH-1:0] abs_dat_t;

  typedef struct packed {
    logic                vld;
    abs_dat_t            dat;
    logic [ABS_ID_W-1:0] id;
    logic                ovf;
  } stage_t;

  function automatic logic is_min_neg_f(input abs_dat_t x);
    return x == {1'b1, {(ABS_WIDTH-1){1'b0}}};
  endfunction

  function automatic abs_dat_t absval_f(input abs_dat_t x);
    abs_dat_t res;
    res = x[ABS_WIDTH-1] ? (~x + 1'b1) : x;
`ifdef ABSVAL_SAT_EN
    // Negating the most-negative value wraps back to itself; clamp it.
    if (is_min_neg_f(x)) begin
      res = {1'b0, {(ABS_WIDTH-1){1'b1}}};
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/absval_rr_arb.sv
// Combinational round-robin arbiter: first valid index at or after rr_ptr.
// Latency: zero (purely combinational).
// Backpressure: none; the caller gates the grant with its own advance condition.
//
// Ports:
//   req_valid [N_REQ] : requesters asking for service
//   rr_ptr    [ID_W]  : highest-priority index this cycle
//   gnt_oh    [N_REQ] : one-hot grant (all zero when nothing is valid)
//   gnt_idx   [ID_W]  : encoded grant index (0 when nothing is valid)
module absval_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]  gnt_idx
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // Walk N_REQ positions starting at the pointer, wrapping modulo N_REQ.
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/absval_rr_sched.sv
// Round-robin scheduler sharing one two-stage signed |x| pipeline among N_REQ requesters.
// Latency: result valid after the second rising edge counting the accepting edge.
// Backpressure: rsp_ready low freezes S2; S1 then fills and all req_ready drop to 0.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (req_ready is one-hot or zero)
//   req_data              : operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data/rsp_id/rsp_ovf : |operand|, requester index, most-negative flag
// Optional feature macro: ABSVAL_SAT_EN (saturating result, see absval_pkg).
module absval_rr_sched
  import absval_pkg::*;
#(
  parameter int WIDTH = ABS_WIDTH,
  parameter int N_REQ = ABS_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_ovf
);

  stage_t           s1_q, s1_d;
  stage_t           s2_q, s2_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]  gnt_idx;
  logic             adv1, adv2, xfer;
  logic [WIDTH-1:0] sel_dat;

  absval_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx)
  );

  assign adv2 = !s2_q.vld || rsp_ready;
  assign adv1 = !s1_q.vld || adv2;

  // Gated by rst_n so no requester sees a grant while reset is held.
  assign req_ready = (adv1 && rst_n) ? gnt_oh : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_dat = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    s1_d     = s1_q;
    s2_d     = s2_q;
    rr_ptr_d = rr_ptr_q;

    if (adv1) begin
      s1_d.vld = xfer;
      if (xfer) begin
        s1_d.dat = sel_dat;
        s1_d.id  = gnt_idx;
        s1_d.ovf = is_min_neg_f(sel_dat);
      end
    end

    if (adv2) begin
      s2_d.vld = s1_q.vld;
      if (s1_q.vld) begin
        s2_d.dat = absval_f(s1_q.dat);
        s2_d.id  = s1_q.id;
        s2_d.ovf = s1_q.ovf;
      end
    end

    if (xfer) begin
      rr_ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = s2_q.vld;
  assign rsp_data  = s2_q.dat;
  assign rsp_id    = s2_q.id;
  assign rsp_ovf   = s2_q.ovf;

endmodule

// File: tb/tb_absval_rr_sched.sv
module tb_absval_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;

  int n_checks = 0;
  int n_errors = 0;

  absval_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called from posedge+1..+2: samples handshakes mid-cycle, advances one
  // edge, then withdraws the requests that were accepted.
  task automatic step();
    logic [3:0] acc;
    #4;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h0102_0304;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_ovf} !== 12'h000) begin
      n_errors++; $display("FAIL reset_rsp got v=%b d=%h id=%0d ovf=%b exp all zero", rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL idle_after_reset got rdy=%b v=%b exp 0000/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_first_request();
    do_reset();
    req_valid = 4'b0010;
    req_data[15:8] = 8'hF6;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL first_grant got=%b exp=0010", req_ready);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL first_latency_early got v=%b exp=0", rsp_valid);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h0A || rsp_id !== 2'd1 || rsp_ovf !== 1'b0) begin
      n_errors++; $display("FAIL first_rsp got v=%b d=%h id=%0d ovf=%b exp 1/0a/1/0", rsp_valid, rsp_data, rsp_id, rsp_ovf);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL first_drain got v=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_throughput();
    logic [1:0] eid;
    do_reset();
    req_data  = {8'hFC, 8'hFD, 8'hFE, 8'hFF};
    req_valid = 4'b1111;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << (cyc % 4))) begin
        n_errors++; $display("FAIL tput_grant cyc=%0d got=%b exp=%b", cyc, req_ready, 4'b0001 << (cyc % 4));
      end
      step();
      req_valid = 4'b1111;
      if (cyc >= 1) begin
        eid = 2'((cyc - 1) % 4);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== 8'({6'd0, eid} + 8'd1)) begin
          n_errors++; $display("FAIL tput_rsp cyc=%0d got v=%b id=%0d d=%h exp id=%0d d=%0d", cyc, rsp_valid, rsp_id, rsp_data, eid, eid + 1);
        end
      end
    end
    req_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_ovf();
    do_reset();
    req_valid = 4'b0001;
    req_data[7:0] = 8'h80;
    step();
    step();
    n_checks++;
`ifdef ABSVAL_SAT_EN
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h7F || rsp_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_min_neg got v=%b d=%h ovf=%b exp 1/7f/1", rsp_valid, rsp_data, rsp_ovf);
    end
`else
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h80 || rsp_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_min_neg got v=%b d=%h ovf=%b exp 1/80/1", rsp_valid, rsp_data, rsp_ovf);
    end
`endif
    req_valid = 4'b0001;
    req_data[7:0] = 8'h7F;
    step();
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h7F || rsp_ovf !== 1'b0) begin
      n_errors++; $display("FAIL ovf_max_pos got v=%b d=%h ovf=%b exp 1/7f/0", rsp_valid, rsp_data, rsp_ovf);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req_data  = {8'h00, 8'h07, 8'h06, 8'h05};
    req_valid = 4'b0111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL bp_grant0 got=%b exp=0001", req_ready);
    end
    step();
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL bp_grant1 got=%b exp=0010", req_ready);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h05) begin
        n_errors++; $display("FAIL bp_full i=%0d got rdy=%b v=%b id=%0d d=%h exp 0000/1/0/05", i, req_ready, rsp_valid, rsp_id, rsp_data);
      end
      step();
    end
    n_checks++;
    if (req_valid !== 4'b0100) begin
      n_errors++; $display("FAIL bp_accept_count pending got=%b exp=0100", req_valid);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_errors++; $display("FAIL bp_release_grant got=%b exp=0100", req_ready);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h06) begin
      n_errors++; $display("FAIL bp_rsp1 got v=%b id=%0d d=%h exp 1/1/06", rsp_valid, rsp_id, rsp_data);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h07 || req_valid !== 4'b0000) begin
      n_errors++; $display("FAIL bp_rsp2 got v=%b id=%0d d=%h pend=%b exp 1/2/07/0000", rsp_valid, rsp_id, rsp_data, req_valid);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_no_dup got v=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    req_data  = {8'h00, 8'h00, 8'hF1, 8'hF0};
    req_valid = 4'b0011;
    step();
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      n_errors++; $display("FAIL rmid_full got v=%b rdy=%b exp 1/0000", rsp_valid, req_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_errors++; $display("FAIL rmid_async got v=%b rdy=%b exp 0/0000", rsp_valid, req_ready);
    end
    req_valid = 4'b1010;
    req_data  = {8'hFD, 8'h00, 8'hFE, 8'h00};
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      n_errors++; $display("FAIL rmid_release got v=%b rdy=%b exp 0/0010", rsp_valid, req_ready);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL rmid_stale got v=%b exp=0", rsp_valid);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h02) begin
      n_errors++; $display("FAIL rmid_first got v=%b id=%0d d=%h exp 1/1/02", rsp_valid, rsp_id, rsp_data);
    end
    req_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_single_requester();
    do_reset();
    req_data = {8'h09, 8'h03, 8'h00, 8'h08};
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0100;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
        n_errors++; $display("FAIL single_grant i=%0d got=%b exp=0100", i, req_ready);
      end
      step();
    end
    req_valid = 4'b1001;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_errors++; $display("FAIL ptr_after_single got=%b exp=1000", req_ready);
    end
    step();
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL ptr_wrap got=%b exp=0001", req_ready);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'h09) begin
      n_errors++; $display("FAIL single_then_3 got v=%b id=%0d d=%h exp 1/3/09", rsp_valid, rsp_id, rsp_data);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h08) begin
      n_errors++; $display("FAIL single_then_0 got v=%b id=%0d d=%h exp 1/0/08", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_throughput();
    test_ovf();
    test_backpressure();
    test_reset_mid();
    test_single_requester();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
